// File: rtl/cpu_pkg.sv
// Shared IF/ID definitions: reset PC, branch bus width, IF-to-ID bus layout.
// Latency: n/a (constants only).
// Backpressure: n/a. Optional macro IF_ADEF_EN adds the adef bit at the bus MSB.
package cpu_pkg;

   localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
   localparam int          BR_BUS_WD   = 33;

   // IF-to-ID bus field offsets: {[adef,] inst[31:0], pc[31:0]}
   localparam int          FS_PC_LSB   = 0;
   localparam int          FS_INST_LSB = 32;
`ifdef IF_ADEF_EN
   localparam int          FS_ADEF_BIT     = 64;
   localparam int          FS_TO_DS_BUS_WD = 65;
`else
   localparam int          FS_TO_DS_BUS_WD = 64;
`endif

endpackage

// File: rtl/if_inst_buf.sv
// Holds SRAM read data while ID stalls so a one-cycle SRAM word is never lost.
// Latency: captures on the clock edge after i_capture; o_inst_buf valid next cycle.
// Backpressure: none; i_clear has priority over i_capture.
// Ports: clk/resetn, i_capture, i_clear, i_rdata[31:0] -> o_buf_valid, o_inst_buf[31:0].
module if_inst_buf (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_capture,
   input  logic        i_clear,
   input  logic [31:0] i_rdata,
   output logic        o_buf_valid,
   output logic [31:0] o_inst_buf
);

   logic        r_buf_valid;
   logic [31:0] r_inst_buf;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_buf_valid <= 1'b0;
         r_inst_buf  <= 32'h0;
      end else if (i_clear) begin
         r_buf_valid <= 1'b0;
      end else if (i_capture) begin
         r_buf_valid <= 1'b1;
         r_inst_buf  <= i_rdata;
      end
   end

   assign o_buf_valid = r_buf_valid;
   assign o_inst_buf  = r_inst_buf;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns PC, drives the 1-cycle inst SRAM, hands {inst,pc} to ID.
// Latency: instruction appears on fs_to_ds_bus one cycle after its SRAM fetch issues.
// Backpressure: valid/allowin with ID; stalls hold the word in if_inst_buf, redirects
// arriving during a stall cancel the stage and are remembered as a pending target.
// Ports: clk/resetn, ds_allowin, br_bus{taken,target} in; fs_to_ds_valid/bus out;
// inst_sram_* SRAM interface. Macro IF_ADEF_EN adds the adef bit and zeroes inst when set.
module if_stage #(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 ds_allowin,
   input  logic [cpu_pkg::BR_BUS_WD-1:0]        br_bus,
   output logic                                 fs_to_ds_valid,
   output logic [cpu_pkg::FS_TO_DS_BUS_WD-1:0]  fs_to_ds_bus,
   output logic                                 inst_sram_en,
   output logic                                 inst_sram_we,
   output logic [31:0]                          inst_sram_addr,
   output logic [31:0]                          inst_sram_wdata,
   input  logic [31:0]                          inst_sram_rdata
);

   logic        r_to_fs_valid;
   logic        r_fs_valid;
   logic [31:0] r_fs_pc;
   logic        r_br_pending;
   logic [31:0] r_pend_target;

   logic        w_br_taken;
   logic [31:0] w_br_target;
   logic [31:0] w_nextpc;
   logic        w_fs_ready_go;
   logic        w_fs_allowin;
   logic        w_buf_valid;
   logic [31:0] w_inst_buf;
   logic [31:0] w_inst_raw;

   assign w_br_taken  = br_bus[32];
   assign w_br_target = br_bus[31:0];

   // ---------------- pre-IF ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_to_fs_valid <= 1'b0;
      else         r_to_fs_valid <= 1'b1;
   end

   assign w_nextpc = w_br_taken   ? w_br_target   :
                     r_br_pending ? r_pend_target :
                                    r_fs_pc + 32'd4;

   assign inst_sram_en    = r_to_fs_valid & w_fs_allowin;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = w_nextpc;
   assign inst_sram_wdata = 32'h0;

   // A redirect that cannot fetch this cycle is parked until the next issued fetch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_br_pending  <= 1'b0;
         r_pend_target <= 32'h0;
      end else begin
         if (inst_sram_en)    r_br_pending <= 1'b0;
         else if (w_br_taken) r_br_pending <= 1'b1;
         if (w_br_taken)      r_pend_target <= w_br_target;
      end
   end

   // ---------------- IF ----------------
   assign w_fs_ready_go = 1'b1;
   assign w_fs_allowin  = ~r_fs_valid | (w_fs_ready_go & ds_allowin);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fs_valid <= 1'b0;
         r_fs_pc    <= RESET_PC - 32'd4;
      end else if (w_fs_allowin) begin
         r_fs_valid <= r_to_fs_valid;
         if (r_to_fs_valid) r_fs_pc <= w_nextpc;
      end else if (w_br_taken) begin
         // wrong-path instruction stuck in a stalled stage: drop it
         r_fs_valid <= 1'b0;
      end
   end

   // The stage content is replaced whenever it advances or is redirected, so the
   // buffered word must go with it.
   if_inst_buf u_inst_buf (
      .clk         (clk),
      .resetn      (resetn),
      .i_capture   (r_fs_valid & ~ds_allowin & ~w_buf_valid),
      .i_clear     (w_fs_allowin | w_br_taken),
      .i_rdata     (inst_sram_rdata),
      .o_buf_valid (w_buf_valid),
      .o_inst_buf  (w_inst_buf)
   );

   assign w_inst_raw     = w_buf_valid ? w_inst_buf : inst_sram_rdata;
   assign fs_to_ds_valid = r_fs_valid & w_fs_ready_go & ~w_br_taken;

`ifdef IF_ADEF_EN
   logic w_adef;
   assign w_adef       = (r_fs_pc[1:0] != 2'b00);
   assign fs_to_ds_bus = {w_adef, (w_adef ? 32'h0 : w_inst_raw), r_fs_pc};
`else
   assign fs_to_ds_bus = {w_inst_raw, r_fs_pc};
`endif

endmodule
